io_cfg_loader: RTL and testbench

- Serial configuration loader directly upstream of the io_block array.
- Receives a framed bitstream and deserialises NUM_BLOCKS configuration words of CFG_W bits.
- Commits all words atomically to the parallel cfg bus that drives each io_block's cfg input.
- Pads never see a partially loaded configuration, because direction/enable bits change in a single clock.

---
 rtl/io_cfg_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_io_cfg_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/io_cfg_loader.sv
// io_cfg_loader
// -------------
// Serial configuration loader for the io_block array. A framed bitstream
// (8-bit sync header, then NUM_BLOCKS*CFG_W payload bits, MSB first) is
// collected in a shadow register. Only a complete frame is copied to cfg_out,
// and that copy happens in a single clock, so the pads never see a partly
// loaded configuration.
//
// Optional build macro: IO_CFG_LOADER_PARITY_EN
//   When defined, one even-parity bit (XOR of all payload bits) follows the
//   payload. A parity mismatch ends the load in ERROR and nothing is committed.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a load (honoured only in IDLE, DONE or ERROR)
//   abort      in   cancel any load and return to IDLE; beats start and bit transfers
//   bit_in     in   serial data bit
//   bit_valid  in   bit_in is valid this cycle
//   bit_ready  out  loader accepts a bit; a transfer is bit_valid && bit_ready
//   cfg_out    out  committed configuration, word k = cfg_out[k*CFG_W +: CFG_W]
//   cfg_valid  out  one-cycle pulse when cfg_out is updated
//   busy       out  load in progress (SYNC, LOAD, PAR, COMMIT)
//   done       out  last load committed successfully, held until next start
//   err        out  last load failed, held until next start
module io_cfg_loader #(
    parameter int          NUM_BLOCKS = 4,
    parameter int          CFG_W      = 6,
    parameter logic [7:0]  HDR        = 8'hA5,
    parameter int          SYNC_MAX   = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        bit_in,
    input  logic                        bit_valid,
    output logic                        bit_ready,
    output logic [NUM_BLOCKS*CFG_W-1:0] cfg_out,
    output logic                        cfg_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int TOTAL   = NUM_BLOCKS * CFG_W;
    localparam int CNT_MAX = (TOTAL > SYNC_MAX) ? (TOTAL + 1) : (SYNC_MAX + 1);
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_LOAD   = 3'd2,
`ifdef IO_CFG_LOADER_PARITY_EN
        ST_PAR    = 3'd3,
`endif
        ST_COMMIT = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [7:0]         hdr_r, hdr_nxt_s;
    logic [7:0]         hdr_shift_s;
    logic [TOTAL-1:0]   shadow_r, shadow_nxt_s;
    logic [TOTAL-1:0]   cfg_out_r, cfg_nxt_s;
    logic               commit_s;
    logic               xfer_s;
    logic               bit_ready_r, busy_r, done_r, err_r, cfg_valid_r;

`ifdef IO_CFG_LOADER_PARITY_EN
    logic               par_r, par_nxt_s;

    // Running even-parity accumulator step.
    function automatic logic par_step(input logic acc, input logic b);
        par_step = acc ^ b;
    endfunction
`endif

    assign xfer_s      = bit_valid && bit_ready_r;
    assign hdr_shift_s = {hdr_r[6:0], bit_in};

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        hdr_nxt_s    = hdr_r;
        shadow_nxt_s = shadow_r;
        cfg_nxt_s    = cfg_out_r;
        commit_s     = 1'b0;
`ifdef IO_CFG_LOADER_PARITY_EN
        par_nxt_s    = par_r;
`endif
        if (abort) begin
            // Abort drops the partial frame; cfg_out is left alone.
            state_nxt_s  = ST_IDLE;
            cnt_nxt_s    = {CNT_W{1'b0}};
            hdr_nxt_s    = 8'h00;
            shadow_nxt_s = {TOTAL{1'b0}};
`ifdef IO_CFG_LOADER_PARITY_EN
            par_nxt_s    = 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_nxt_s  = ST_SYNC;
                        cnt_nxt_s    = {CNT_W{1'b0}};
                        hdr_nxt_s    = 8'h00;
                        shadow_nxt_s = {TOTAL{1'b0}};
`ifdef IO_CFG_LOADER_PARITY_EN
                        par_nxt_s    = 1'b0;
`endif
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_SYNC: begin
                    if (xfer_s) begin
                        hdr_nxt_s = hdr_shift_s;
                        // A match on the last permitted bit still wins.
                        if (hdr_shift_s == HDR) begin
                            state_nxt_s = ST_LOAD;
                            cnt_nxt_s   = {CNT_W{1'b0}};
                        end else if (cnt_r == CNT_W'(SYNC_MAX - 1)) begin
                            state_nxt_s = ST_ERROR;
                            cnt_nxt_s   = cnt_r + 1'b1;
                        end else begin
                            cnt_nxt_s   = cnt_r + 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_SYNC;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        shadow_nxt_s = {shadow_r[TOTAL-2:0], bit_in};
`ifdef IO_CFG_LOADER_PARITY_EN
                        par_nxt_s    = par_step(par_r, bit_in);
`endif
                        if (cnt_r == CNT_W'(TOTAL - 1)) begin
`ifdef IO_CFG_LOADER_PARITY_EN
                            state_nxt_s = ST_PAR;
`else
                            state_nxt_s = ST_COMMIT;
`endif
                            cnt_nxt_s   = {CNT_W{1'b0}};
                        end else begin
                            cnt_nxt_s   = cnt_r + 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
`ifdef IO_CFG_LOADER_PARITY_EN
                ST_PAR: begin
                    if (xfer_s) begin
                        if (bit_in == par_r) begin
                            state_nxt_s = ST_COMMIT;
                        end else begin
                            state_nxt_s = ST_ERROR;
                        end
                    end else begin
                        state_nxt_s = ST_PAR;
                    end
                end
`endif
                ST_COMMIT: begin
                    cfg_nxt_s   = shadow_r;
                    commit_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers: header search, shadow, counter, committed config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            hdr_r     <= 8'h00;
            shadow_r  <= {TOTAL{1'b0}};
            cfg_out_r <= {TOTAL{1'b0}};
`ifdef IO_CFG_LOADER_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            cnt_r     <= cnt_nxt_s;
            hdr_r     <= hdr_nxt_s;
            shadow_r  <= shadow_nxt_s;
            cfg_out_r <= cfg_nxt_s;
`ifdef IO_CFG_LOADER_PARITY_EN
            par_r     <= par_nxt_s;
`endif
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cfg_valid_r <= 1'b0;
        end else begin
            bit_ready_r <= (state_nxt_s == ST_SYNC) || (state_nxt_s == ST_LOAD)
`ifdef IO_CFG_LOADER_PARITY_EN
                           || (state_nxt_s == ST_PAR)
`endif
                           ;
            busy_r      <= (state_nxt_s == ST_SYNC) || (state_nxt_s == ST_LOAD)
`ifdef IO_CFG_LOADER_PARITY_EN
                           || (state_nxt_s == ST_PAR)
`endif
                           || (state_nxt_s == ST_COMMIT);
            done_r      <= (state_nxt_s == ST_DONE);
            err_r       <= (state_nxt_s == ST_ERROR);
            cfg_valid_r <= commit_s;
        end
    end

    assign bit_ready = bit_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign cfg_valid = cfg_valid_r;
    assign cfg_out   = cfg_out_r;

endmodule

// File: tb/tb_io_cfg_loader.sv
// Directed testbench for io_cfg_loader (NUM_BLOCKS=4, CFG_W=6, HDR=8'hA5).
// Define IO_CFG_LOADER_PARITY_EN for both files to exercise the parity build.
module tb_io_cfg_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [23:0] cfg_out;
    logic        cfg_valid;
    logic        busy;
    logic        done;
    logic        err;

    int passed = 0;
    int total  = 0;
    int vpulse = 0;
    logic ready_drop = 1'b0;

    io_cfg_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .cfg_out   (cfg_out),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count commit pulses seen at each rising edge.
    always @(posedge clk) begin
        if (cfg_valid) vpulse++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Send the low n bits of v, MSB first; optional idle cycle between bits.
    task automatic send_vec(input logic [31:0] v, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            int   guard;
            logic rdy;
            bit_in    = v[i];
            bit_valid = 1'b1;
            guard     = 0;
            do begin
                rdy = bit_ready;
                tick();
                guard++;
            end while (!rdy && guard < 50);
            if (!rdy) ready_drop = 1'b1;
            bit_valid = 1'b0;
            if (gap && i > 0) tick();
        end
    endtask

    // Header + 24-bit payload (+ parity bit in the parity build).
    task automatic load(input logic [23:0] d, input bit gap, input logic par_flip);
        send_vec(32'h000000A5, 8, gap);
        if (gap) tick();
        send_vec({8'h00, d}, 24, gap);
`ifdef IO_CFG_LOADER_PARITY_EN
        if (gap) tick();
        send_vec({31'h0, (^d) ^ par_flip}, 1, 1'b0);
`endif
    endtask

    // Checks the commit edge that follows the last sampled bit.
    task automatic commit_check(input string tag, input logic [23:0] exp);
        chk({tag, "_pre_valid"}, {31'h0, cfg_valid}, 32'h0);
        tick();
        chk({tag, "_cfg_out"}, {8'h0, cfg_out}, {8'h0, exp});
        chk({tag, "_valid"}, {31'h0, cfg_valid}, 32'h1);
        chk({tag, "_done"}, {31'h0, done}, 32'h1);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        tick();
        chk({tag, "_valid_drop"}, {31'h0, cfg_valid}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        #23;
        rst_n = 1'b1;
        tick();

        // 1: reset state
        chk("rst_cfg_out", {8'h0, cfg_out}, 32'h0);
        chk("rst_bit_ready", {31'h0, bit_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);

        // 2: clean load of 24'h123456
        do_start();
        chk("s2_busy", {31'h0, busy}, 32'h1);
        chk("s2_ready", {31'h0, bit_ready}, 32'h1);
        load(24'h123456, 1'b0, 1'b0);
        chk("s2_hold_old", {8'h0, cfg_out}, 32'h0);
        commit_check("s2", 24'h123456);
        chk("s2_word3", {26'h0, cfg_out[23:18]}, 32'h04);
        chk("s2_word0", {26'h0, cfg_out[5:0]}, 32'h16);
        chk("s2_pulses", vpulse, 32'd1);

        // 3: junk bits before header, bit_valid every other cycle
        do_start();
        chk("s3_done_clr", {31'h0, done}, 32'h0);
        ready_drop = 1'b0;
        send_vec(32'h5, 3, 1'b1);
        tick();
        load(24'h123456, 1'b1, 1'b0);
        commit_check("s3", 24'h123456);
        chk("s3_ready_held", {31'h0, ready_drop}, 32'h0);
        chk("s3_pulses", vpulse, 32'd2);

        // 4: no header within 64 bits
        do_start();
        send_vec(32'h0, 32, 1'b0);
        send_vec(32'h0, 31, 1'b0);
        chk("s4_err_63", {31'h0, err}, 32'h0);
        chk("s4_busy_63", {31'h0, busy}, 32'h1);
        send_vec(32'h0, 1, 1'b0);
        chk("s4_err_64", {31'h0, err}, 32'h1);
        chk("s4_busy_64", {31'h0, busy}, 32'h0);
        chk("s4_ready_64", {31'h0, bit_ready}, 32'h0);
        chk("s4_cfg_hold", {8'h0, cfg_out}, 32'h123456);
        chk("s4_pulses", vpulse, 32'd2);

        // 5: abort mid-payload, then full reload
        do_start();
        chk("s5_err_clr", {31'h0, err}, 32'h0);
        send_vec(32'h000000A5, 8, 1'b0);
        send_vec(32'h3FF, 10, 1'b0);
        abort = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        tick();
        abort = 1'b0;
        bit_valid = 1'b0;
        chk("s5_abort_busy", {31'h0, busy}, 32'h0);
        chk("s5_abort_ready", {31'h0, bit_ready}, 32'h0);
        chk("s5_abort_cfg", {8'h0, cfg_out}, 32'h123456);
        chk("s5_abort_done", {31'h0, done}, 32'h0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("s5_abort_beats_start", {31'h0, busy}, 32'h0);
        do_start();
        load(24'hABCDEF, 1'b0, 1'b0);
        commit_check("s5", 24'hABCDEF);

`ifdef IO_CFG_LOADER_PARITY_EN
        // 6: parity build - wrong parity, then right parity
        do_start();
        load(24'h123456, 1'b0, 1'b1);
        chk("s6_bad_err", {31'h0, err}, 32'h1);
        chk("s6_bad_cfg", {8'h0, cfg_out}, 32'hABCDEF);
        tick();
        chk("s6_bad_novalid", {31'h0, cfg_valid}, 32'h0);
        do_start();
        load(24'h123456, 1'b0, 1'b0);
        commit_check("s6", 24'h123456);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
